// File: rtl/burst_memory_pkg.sv
// Shared types for the burst memory: access-size encodings, the beat-count
// helper and the burst FSM state encoding.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_1W  = 2'b00,
        SZ_4W  = 2'b01,
        SZ_8W  = 2'b10,
        SZ_16W = 2'b11
    } access_size_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RD_BURST = 2'b01,
        WR_BURST = 2'b10
    } state_t;

    // Number of word beats in a burst for a given access_size code.
    function automatic logic [4:0] beats(input logic [1:0] size);
        logic [4:0] n;
        case (size)
            SZ_1W:   n = 5'd1;
            SZ_4W:   n = 5'd4;
            SZ_8W:   n = 5'd8;
            default: n = 5'd16;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/burst_memory_if.sv
// Request/response bundle between a pipeline stage and the burst memory.
// Handshake: enable acts as the request valid and ~busy as ready; a request
// is taken on any posedge where enable=1 and busy=0, and enable is ignored
// while busy is high. data_valid marks a read beat on data_out for exactly
// the cycle after that beat executes; there is no back-pressure on reads.
interface burst_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [1:0]            access_size;
    logic                  rw;
    logic                  enable;
    logic                  busy;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  error;

    modport master (
        output address, data_in, access_size, rw, enable,
        input  busy, data_out, data_valid, error
    );

    modport slave (
        input  address, data_in, access_size, rw, enable,
        output busy, data_out, data_valid, error
    );
endinterface

// File: rtl/burst_memory_byte_ram.sv
// Byte-organised storage with one word-wide big-endian port: the byte at
// addr maps to the most significant byte of the word. Read is combinational
// so a write on one edge is visible to a read on the next.
module byte_ram #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_BYTES = 1048576
) (
    input  logic                           clock,
    input  logic [$clog2(DEPTH_BYTES)-1:0] addr,
    input  logic                           we,
    input  logic [DATA_WIDTH-1:0]          wdata,
    output logic [DATA_WIDTH-1:0]          rdata
);
    localparam int AW  = $clog2(DEPTH_BYTES);
    localparam int BPW = DATA_WIDTH / 8;

    logic [7:0] mem [DEPTH_BYTES];

    // Store one word, most significant byte at the lowest address.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < BPW; i++) begin
                mem[addr + AW'(i)] <= wdata[DATA_WIDTH-1-8*i -: 8];
            end
        end
    end

    // Assemble the word at addr, most significant byte first.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < BPW; i++) begin
            rdata[DATA_WIDTH-1-8*i -: 8] = mem[addr + AW'(i)];
        end
    end
endmodule

// File: rtl/burst_memory.sv
// Burst memory for the MIPS pipeline: one request port, 1/4/8/16-word
// bursts, registered read data with a valid strobe, and a base-address
// window whose out-of-range beats are flagged with error.
module burst_memory
    import mem_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_BYTES = 1048576,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8002_0000
) (
    input  logic               clock,
    input  logic               reset,
    burst_memory_if.slave      bus,
    output state_t             dbg_state
);
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int OFF_W          = $clog2(DEPTH_BYTES);
    localparam int SHIFT          = $clog2(BYTES_PER_WORD);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES_PER_WORD - 1);
    // Highest offset at which a whole word still fits in storage.
    localparam logic [ADDR_WIDTH-1:0] LAST_OK = ADDR_WIDTH'(DEPTH_BYTES - BYTES_PER_WORD);

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic [3:0]            last, last_nxt;
    logic [ADDR_WIDTH-1:0] lat_addr, lat_addr_nxt;

    logic                  beat_active;
    logic                  beat_rw;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  in_range;
    logic [4:0]            req_beats;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  data_valid_q;
    logic                  error_q;

    assign req_beats = beats(bus.access_size);

    // Burst state, beat counter and latched request; all cleared by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            last     <= '0;
            lat_addr <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            last     <= last_nxt;
            lat_addr <= lat_addr_nxt;
        end
    end

    // Decide which beat executes this edge and where the FSM goes next.
    // In IDLE the beat comes straight from the inputs (beat 0); in a burst
    // it comes from the latched base plus the counter.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        last_nxt     = last;
        lat_addr_nxt = lat_addr;
        beat_active  = 1'b0;
        beat_rw      = 1'b0;
        beat_addr    = lat_addr + (ADDR_WIDTH'(cnt) << SHIFT);
        case (state)
            IDLE: begin
                if (bus.enable) begin
                    beat_active = 1'b1;
                    beat_rw     = bus.rw;
                    beat_addr   = bus.address & ALIGN_MASK;
                    if (req_beats != 5'd1) begin
                        state_nxt    = bus.rw ? WR_BURST : RD_BURST;
                        cnt_nxt      = 4'd1;
                        last_nxt     = 4'(req_beats - 5'd1);
                        lat_addr_nxt = bus.address & ALIGN_MASK;
                    end
                end
            end
            RD_BURST, WR_BURST: begin
                beat_active = 1'b1;
                beat_rw     = (state == WR_BURST);
                if (cnt == last) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Unsigned subtraction: addresses below the base wrap to huge offsets
    // and so fall out of range as well.
    assign offset   = beat_addr - BASE_ADDR;
    assign in_range = (offset <= LAST_OK);

    byte_ram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_ram (
        .clock (clock),
        .addr  (offset[OFF_W-1:0]),
        .we    (beat_active & beat_rw & in_range & ~reset),
        .wdata (bus.data_in),
        .rdata (ram_rdata)
    );

    // Registered read data, valid strobe and per-beat range error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            data_valid_q <= beat_active & ~beat_rw;
            error_q      <= beat_active & ~in_range;
            if (beat_active && !beat_rw) begin
                data_out_q <= in_range ? ram_rdata : '0;
            end
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.error      = error_q;
    assign dbg_state      = state;
endmodule

// File: doc/burst_memory.md
Name: burst_memory

Overview:
- Parametrised, byte-addressable, big-endian instruction/data memory model for the MIPS pipeline.
- Adds four things over single-word access: a proper read/write burst state machine, registered read data with a valid strobe, a base-address window with range error, and asynchronous reset.
- Serves fetch and load/store stages through one request port; bursts of 1/4/8/16 words are selected by access_size.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8 (BYTES_PER_WORD = DATA_WIDTH/8, localparam).
- ADDR_WIDTH, 32, byte address width.
- DEPTH_BYTES, 1048576, storage size in bytes.
- BASE_ADDR, 32'h8002_0000, byte address mapped to storage byte 0.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- address  in  ADDR_WIDTH  start byte address; low log2(BYTES_PER_WORD) bits ignored (forced 0).
- data_in  in  DATA_WIDTH  write data, one word per beat.
- access_size  in  2  00=1 word, 01=4, 10=8, 11=16 words.
- rw  in  1  1=write, 0=read.
- enable  in  1  request strobe.
- busy  out  1  burst in progress; new requests ignored.
- data_out  out  DATA_WIDTH  registered read data.
- data_valid  out  1  data_out holds a read beat this cycle.
- error  out  1  registered; current beat address outside window.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, data_valid=0, data_out=0, error=0, beat counter=0. Storage contents are not cleared. A burst in flight is aborted; no further beats are written or read.
- Acceptance: request accepted at a posedge where enable=1 and busy=0. At acceptance, address (aligned), rw and access_size are latched. Later changes to inputs have no effect until the burst ends.
- N = beats(access_size). Beat k (k=0..N-1) executes at the k-th posedge counted from acceptance (acceptance posedge = beat 0).
  - Beat address = latched_addr + k*BYTES_PER_WORD.
- busy: rises at acceptance posedge if N>1; falls at the posedge executing beat N-1. Single-word accesses never assert busy, so back-to-back single accesses every cycle are allowed. A new request can be accepted the cycle after the last beat.
- Read beat k: data_out <= word at beat address, data_valid <= 1 (visible in the cycle after posedge k).
  - Big-endian: byte at beat address drives data_out[DATA_WIDTH-1 -: 8].
  - data_valid drops to 0 on any posedge with no read beat. data_out holds its last value.
- Write beat k: data_in sampled at posedge k is stored big-endian at the beat address. data_valid stays 0.
- Range: offset = beat address - BASE_ADDR (unsigned). If offset+BYTES_PER_WORD > DEPTH_BYTES:
  - write beat is dropped;
  - read beat returns 0 with data_valid=1;
  - error=1 for that beat's cycle.
  - Checked per beat: a burst crossing the top edge errors only on out-of-range beats. There is no wrap-around.
- Read-after-write: a read accepted the cycle after a write beat returns the new data.
- FSM states and transitions:
  - IDLE -> RD_BURST / WR_BURST on acceptance with N>1. For N=1 the single beat executes and the FSM stays in IDLE.
  - RD_BURST / WR_BURST -> IDLE at beat N-1.
  - Any state -> IDLE on reset.

Decomposition:
- Package mem_pkg:
  - access_size encodings: SZ_1W, SZ_4W, SZ_8W, SZ_16W;
  - function beats(size) returning 1/4/8/16;
  - state enum IDLE/RD_BURST/WR_BURST.
- Sub-module byte_ram: DEPTH_BYTES x 8 storage with one word-wide big-endian read/write port (addr, we, wdata, rdata, combinational read). burst_memory holds the FSM, counter, range check and output registers.

Test Plan:
- Reset mid-burst: 16-word read accepted, reset asserted after beat 5 -> busy=0, data_valid=0, data_out=0 immediately. A following 1-word read returns preserved contents.
- Single write/read: write 0xDEADBEEF at 0x80020000, then read same address next cycle -> data_out=0xDEADBEEF, data_valid=1 for one cycle. Byte 0x80020000 reads 0xDE via 1-word read at 0x80020000 with mask check. busy never asserted.
- 4-word write burst at 0x80020010 with data 0x11111111..0x44444444 -> busy high 3 cycles. Then 8-word read from 0x80020010 -> beats 0..3 return written words in order, busy high 7 cycles, data_valid high 8 consecutive cycles.
- Input changes mid-burst: change address/rw/access_size and pulse enable during an 8-word read -> ignored; burst completes with original addresses and length.
- Range edge: 4-word read at BASE_ADDR+DEPTH_BYTES-8 -> beats 0,1 valid data, error=0; beats 2,3 data_out=0, error=1. A write at BASE_ADDR-4 leaves storage unchanged, error=1.
- Back-to-back: 1-word reads on 5 consecutive cycles at 0x80020000+4k -> 5 consecutive data_valid cycles, matching words, busy=0 throughout.
